// File: rtl/ivl_uvm_ovl_time_multi.sv
// Multi-channel OVL time checker: per-channel window of NUM_CKS clocks
// in which test_expr must hold, with aggregate fire bits and error count.
module ivl_uvm_ovl_time_multi #(
    parameter int unsigned CHANNELS       = 4,
    parameter int unsigned NUM_CKS        = 2,
    parameter int unsigned NEW_START_MODE = 1,
    parameter int unsigned ERR_CNT_W      = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [CHANNELS-1:0]  start_event,
    input  logic [CHANNELS-1:0]  test_expr,
    output logic [2:0]           fire,
    output logic [CHANNELS-1:0]  err_ch,
    output logic [CHANNELS-1:0]  active,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int unsigned CW = $clog2(NUM_CKS + 1);
    localparam int unsigned PW = $clog2(CHANNELS + 1);
    localparam logic [CW-1:0] LOAD = CW'(NUM_CKS);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic {IDLE, ACTIVE} state_e;

    state_e               state_q [CHANNELS];
    state_e               state_d [CHANNELS];
    logic [CW-1:0]        cnt_q   [CHANNELS];
    logic [CW-1:0]        cnt_d   [CHANNELS];
    logic [CHANNELS-1:0]  err_d;
    logic [CHANNELS-1:0]  open_d;
    logic [CHANNELS-1:0]  done_d;
    logic [CHANNELS-1:0]  err_ch_q;
    logic [2:0]           fire_q;
    logic [2:0]           fire_d;
    logic [ERR_CNT_W-1:0] err_count_q;
    logic [ERR_CNT_W-1:0] err_count_d;
    logic [PW-1:0]        pop;
    logic [ERR_CNT_W:0]   sum;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            err_ch_q    <= '0;
            fire_q      <= '0;
            err_count_q <= '0;
        end else begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            err_ch_q    <= err_d;
            fire_q      <= fire_d;
            err_count_q <= err_count_d;
        end
    end

    // Failure beats new-start handling, which beats the countdown.
    always_comb begin
        err_d  = '0;
        open_d = '0;
        done_d = '0;
        active = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            active[i]  = (state_q[i] == ACTIVE);
            if (!enable) begin
                state_d[i] = IDLE;
                cnt_d[i]   = '0;
            end else begin
                unique case (state_q[i])
                    IDLE: begin
                        if (start_event[i]) begin
                            state_d[i] = ACTIVE;
                            cnt_d[i]   = LOAD;
                            open_d[i]  = 1'b1;
                        end
                    end
                    ACTIVE: begin
                        if (!test_expr[i]) begin
                            err_d[i]   = 1'b1;
                            state_d[i] = IDLE;
                            cnt_d[i]   = '0;
                        end else if (start_event[i] && NEW_START_MODE == 1) begin
                            cnt_d[i]  = LOAD;
                            open_d[i] = 1'b1;
                        end else begin
                            if (start_event[i] && NEW_START_MODE == 2) begin
                                err_d[i] = 1'b1;
                            end
                            if (cnt_q[i] == ONE) begin
                                state_d[i] = IDLE;
                                cnt_d[i]   = '0;
                                done_d[i]  = 1'b1;
                            end else begin
                                cnt_d[i] = cnt_q[i] - ONE;
                            end
                        end
                    end
                endcase
            end
        end
    end

    // Saturating accumulate; pop never exceeds the counter range.
    always_comb begin
        pop = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            pop = pop + PW'(err_d[i]);
        end
        sum         = {1'b0, err_count_q} + (ERR_CNT_W + 1)'(pop);
        err_count_d = sum[ERR_CNT_W] ? '1 : sum[ERR_CNT_W-1:0];
        fire_d      = {|done_d, |open_d, |err_d};
    end

    assign fire      = fire_q;
    assign err_ch    = err_ch_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_ivl_uvm_ovl_time_multi.sv
// Scoreboard bench: five checker instances on shared stimulus, each
// compared every cycle against a behavioural window model.
module tb_ivl_uvm_ovl_time_multi;

    localparam int NI = 5;
    localparam int NA [NI] = '{2, 3, 3, 3, 1};
    localparam int MA [NI] = '{1, 1, 2, 0, 0};

    typedef struct packed {
        logic [2:0]  fire;
        logic [3:0]  err;
        logic [3:0]  act;
        logic [15:0] ec;
    } obs_t;
    typedef obs_t [NI-1:0] obs5_t;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [3:0]  start_event;
    logic [3:0]  test_expr;
    logic [2:0]  fire_w [NI];
    logic [3:0]  err_w  [NI];
    logic [3:0]  act_w  [NI];
    logic [15:0] ec_w   [NI];

    int    n_vec = 0;
    int    n_bad = 0;
    int    m_act [NI][4];
    int    m_cnt [NI][4];
    int    m_ec  [NI];
    obs5_t exp_q [$];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        ivl_uvm_ovl_time_multi #(
            .CHANNELS      (4),
            .NUM_CKS       (NA[g]),
            .NEW_START_MODE(MA[g]),
            .ERR_CNT_W     (16)
        ) u_dut (
            .clock      (clock),
            .reset      (reset),
            .enable     (enable),
            .start_event(start_event),
            .test_expr  (test_expr),
            .fire       (fire_w[g]),
            .err_ch     (err_w[g]),
            .active     (act_w[g]),
            .err_count  (ec_w[g])
        );
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic obs_t obs_of(input int g);
        obs_t o;
        o.fire = fire_w[g];
        o.err  = err_w[g];
        o.act  = act_w[g];
        o.ec   = ec_w[g];
        return o;
    endfunction

    function automatic void model_clear();
        for (int g = 0; g < NI; g++) begin
            m_ec[g] = 0;
            for (int i = 0; i < 4; i++) begin
                m_act[g][i] = 0;
                m_cnt[g][i] = 0;
            end
        end
    endfunction

    function automatic obs5_t model_step(input logic en,
                                         input logic [3:0] st,
                                         input logic [3:0] te);
        obs5_t r;
        logic [3:0] e, o, d;
        int s;
        for (int g = 0; g < NI; g++) begin
            e = '0;
            o = '0;
            d = '0;
            for (int i = 0; i < 4; i++) begin
                if (!en) begin
                    m_act[g][i] = 0;
                    m_cnt[g][i] = 0;
                end else if (m_act[g][i] == 0) begin
                    if (st[i]) begin
                        m_act[g][i] = 1;
                        m_cnt[g][i] = NA[g];
                        o[i] = 1'b1;
                    end
                end else if (!te[i]) begin
                    e[i] = 1'b1;
                    m_act[g][i] = 0;
                end else if (st[i] && MA[g] == 1) begin
                    m_cnt[g][i] = NA[g];
                    o[i] = 1'b1;
                end else begin
                    if (st[i] && MA[g] == 2) e[i] = 1'b1;
                    m_cnt[g][i]--;
                    if (m_cnt[g][i] == 0) begin
                        m_act[g][i] = 0;
                        d[i] = 1'b1;
                    end
                end
                r[g].act[i] = (m_act[g][i] != 0);
            end
            s = m_ec[g] + $countones(e);
            m_ec[g] = (s > 65535) ? 65535 : s;
            r[g].fire = {|d, |o, |e};
            r[g].err  = e;
            r[g].ec   = 16'(m_ec[g]);
        end
        return r;
    endfunction

    task automatic cyc(input logic e, input logic [3:0] s,
                       input logic [3:0] t);
        obs5_t y;
        enable      = e;
        start_event = s;
        test_expr   = t;
        exp_q.push_back(model_step(e, s, t));
        @(posedge clock);
        #1;
        y = exp_q.pop_front();
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("sb_u%0d", g), 32'(obs_of(g)), 32'(y[g]));
        end
    endtask

    initial begin
        logic [3:0] t3_st;
        int n_open;
        int n_done;
        int pre;
        int n;
        reset       = 1'b0;
        enable      = 1'b0;
        start_event = '0;
        test_expr   = '0;
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("rst_u%0d", g), 32'(obs_of(g)), 32'd0);
        end
        reset = 1'b1;

        // clean window on ch0
        cyc(1, 4'h1, 4'h1);
        chk("t1_open", 32'(fire_w[0]), 32'(3'b010));
        chk("t1_act0", 32'(act_w[0]), 32'(4'b0001));
        cyc(1, 4'h0, 4'h1);
        chk("t1_act1", 32'(act_w[0]), 32'(4'b0001));
        cyc(1, 4'h0, 4'h1);
        chk("t1_done", 32'(fire_w[0]), 32'(3'b100));
        chk("t1_act2", 32'(act_w[0]), 32'd0);
        chk("t1_ec", 32'(ec_w[0]), 32'd0);
        cyc(1, 4'h0, 4'h1);
        cyc(1, 4'h0, 4'h0);

        // failure at t2
        cyc(1, 4'h1, 4'h1);
        cyc(1, 4'h0, 4'h1);
        cyc(1, 4'h0, 4'h0);
        chk("t2_err", 32'(err_w[0]), 32'(4'b0001));
        chk("t2_fire0", 32'(fire_w[0][0]), 32'd1);
        chk("t2_act", 32'(act_w[0][0]), 32'd0);
        chk("t2_ec", 32'(ec_w[0]), 32'd1);
        cyc(1, 4'h0, 4'h0);

        // restart at t2, NUM_CKS=3 mode 1
        t3_st  = 4'b0101;
        n_open = 0;
        n_done = 0;
        for (int k = 0; k < 6; k++) begin
            cyc(1, (k < 4) ? {3'b000, t3_st[k]} : 4'h0, 4'h1);
            n_open += int'(fire_w[1][1]);
            n_done += int'(fire_w[1][2]);
            chk($sformatf("t3_act_k%0d", k), 32'(act_w[1][0]),
                32'(k < 5));
        end
        chk("t3_opens", 32'(n_open), 32'd2);
        chk("t3_dones", 32'(n_done), 32'd1);
        cyc(1, 4'h0, 4'h0);

        // start re-asserted at t1: mode 2 flags, mode 0 ignores
        cyc(1, 4'h1, 4'h1);
        cyc(1, 4'h1, 4'h1);
        chk("t4_m2_err", 32'(err_w[2]), 32'(4'b0001));
        chk("t4_m0_err", 32'(err_w[3]), 32'd0);
        cyc(1, 4'h0, 4'h1);
        cyc(1, 4'h0, 4'h1);
        chk("t4_m2_done", 32'(fire_w[2]), 32'(3'b100));
        chk("t4_m0_done", 32'(fire_w[3]), 32'(3'b100));
        cyc(1, 4'h0, 4'h1);
        cyc(1, 4'h0, 4'h0);

        // simultaneous failures on ch1 and ch3
        cyc(1, 4'b1010, 4'hF);
        pre = m_ec[0];
        cyc(1, 4'h0, 4'h0);
        chk("t5_err", 32'(err_w[0]), 32'(4'b1010));
        chk("t5_ec", 32'(ec_w[0]), 32'(pre + 2));
        cyc(1, 4'h0, 4'h0);

        // pump the mode-2 counter up to FFFE, then overflow it
        n = 0;
        while (m_ec[2] < 16'hFFF0 && n < 30000) begin
            cyc(1, 4'hF, 4'hF);
            n++;
        end
        while (m_ec[2] < 16'hFFFE && n < 30000) begin
            cyc(1, 4'h1, 4'hF);
            n++;
        end
        chk("pump_budget", 32'(n < 30000), 32'd1);
        chk("sat_pre", 32'(ec_w[2]), 32'hFFFE);
        repeat (4) cyc(1, 4'hF, 4'hF);
        chk("sat_hold", 32'(ec_w[2]), 32'hFFFF);
        cyc(1, 4'hF, 4'hF);
        chk("sat_hold2", 32'(ec_w[2]), 32'hFFFF);

        // reset mid-window
        cyc(1, 4'hF, 4'hF);
        reset = 1'b0;
        #1;
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("rst_mid_u%0d", g), 32'(obs_of(g)), 32'd0);
        end
        model_clear();
        @(posedge clock);
        #1;
        chk("rst_hold", 32'(obs_of(2)), 32'd0);
        reset = 1'b1;
        cyc(1, 4'h0, 4'h0);

        // enable dropped mid-window
        cyc(1, 4'h1, 4'h0);
        cyc(1, 4'h0, 4'h0);
        chk("en_pre", 32'(ec_w[0]), 32'd1);
        cyc(1, 4'hF, 4'hF);
        cyc(1, 4'h0, 4'hF);
        cyc(0, 4'hF, 4'h0);
        chk("en_act", 32'(act_w[0]), 32'd0);
        chk("en_err", 32'(err_w[0]), 32'd0);
        chk("en_fire", 32'(fire_w[0]), 32'd0);
        chk("en_ec", 32'(ec_w[0]), 32'd1);
        cyc(0, 4'hF, 4'hF);
        cyc(1, 4'h0, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
